// File: rtl/if_id_stage.sv
// Thumb fetch unit and IF/ID pipeline register with a one-entry skid buffer and branch redirect.
// Latency: a response loads IF/ID on the edge that samples it; IMEM_REQ rises on the first edge after reset.
// Backpressure: STALL holds IF/ID, one extra response parks in the skid and fetch pauses until STALL drops.
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        id_valid,
    output logic [15:0] instr,
    output logic [31:0] pc_id,
    output logic [2:0]  imm3,
    output logic [4:0]  imm5,
    output logic [7:0]  imm8,
    output logic [10:0] imm11,
    output logic [2:0]  rd,
    output logic [2:0]  rs,
    output logic [2:0]  rn
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        SKID    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        started;
    logic        pend, pend_nxt;
    logic [31:0] fpc, fpc_nxt;
    logic [31:0] tgt_q, tgt_nxt;
    logic [15:0] skid_instr, skid_instr_nxt;
    logic [31:0] skid_pc, skid_pc_nxt;
    logic [15:0] instr_nxt;
    logic [31:0] pc_id_nxt;
    logic        id_valid_nxt;
    logic        rsp_acc;
    logic [31:0] br_tgt;

    assign br_tgt    = branch_target & ~32'd1;
    assign imem_req  = started && (state != SKID);
    assign imem_addr = fpc;

    // A response only counts once its request has been visible for a full cycle,
    // which filters strobes left over from a request abandoned by reset.
    assign rsp_acc  = imem_valid && pend;
    assign pend_nxt = imem_req && !rsp_acc;

    always_comb begin
        state_nxt      = state;
        fpc_nxt        = fpc;
        tgt_nxt        = tgt_q;
        skid_instr_nxt = skid_instr;
        skid_pc_nxt    = skid_pc;
        instr_nxt      = instr;
        pc_id_nxt      = pc_id;
        id_valid_nxt   = id_valid;

        if (branch_taken) begin
            id_valid_nxt   = 1'b0;
            skid_instr_nxt = 16'h0000;
            skid_pc_nxt    = 32'h0;
            // An in-flight request must drain before the target can be presented.
            if (imem_req && !rsp_acc) begin
                state_nxt = DISCARD;
                tgt_nxt   = br_tgt;
            end else begin
                state_nxt = FETCH;
                fpc_nxt   = br_tgt;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (rsp_acc) begin
                        fpc_nxt = fpc + 32'd2;
                        if (stall && id_valid) begin
                            skid_instr_nxt = imem_rdata;
                            skid_pc_nxt    = fpc;
                            state_nxt      = SKID;
                        end else begin
                            instr_nxt    = imem_rdata;
                            pc_id_nxt    = fpc;
                            id_valid_nxt = 1'b1;
                        end
                    end else if (!stall) begin
                        id_valid_nxt = 1'b0;
                    end
                end
                SKID: begin
                    if (!stall) begin
                        instr_nxt    = skid_instr;
                        pc_id_nxt    = skid_pc;
                        id_valid_nxt = 1'b1;
                        state_nxt    = FETCH;
                    end
                end
                DISCARD: begin
                    id_valid_nxt = 1'b0;
                    if (rsp_acc) begin
                        fpc_nxt   = tgt_q;
                        state_nxt = FETCH;
                    end
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            started    <= 1'b0;
            pend       <= 1'b0;
            fpc        <= RESET_PC;
            tgt_q      <= 32'h0;
            skid_instr <= 16'h0000;
            skid_pc    <= 32'h0;
            instr      <= 16'h0000;
            pc_id      <= 32'h0;
            id_valid   <= 1'b0;
        end else begin
            state      <= state_nxt;
            started    <= 1'b1;
            pend       <= pend_nxt;
            fpc        <= fpc_nxt;
            tgt_q      <= tgt_nxt;
            skid_instr <= skid_instr_nxt;
            skid_pc    <= skid_pc_nxt;
            instr      <= instr_nxt;
            pc_id      <= pc_id_nxt;
            id_valid   <= id_valid_nxt;
        end
    end

    assign imm3  = instr[8:6];
    assign imm5  = instr[10:6];
    assign imm8  = instr[7:0];
    assign imm11 = instr[10:0];
    assign rd    = instr[2:0];
    assign rs    = instr[5:3];
    assign rn    = instr[8:6];

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: latency-programmable instruction memory plus an in-order
// instruction-stream model that every consumed IF/ID entry is checked against.
module tb_if_id_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        id_valid;
    logic [15:0] instr;
    logic [31:0] pc_id;
    logic [2:0]  imm3;
    logic [4:0]  imm5;
    logic [7:0]  imm8;
    logic [10:0] imm11;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rn;

    int n_chk = 0;
    int n_err = 0;
    int n_cons = 0;
    int cons0;

    if_id_stage #(.RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .id_valid      (id_valid),
        .instr         (instr),
        .pc_id         (pc_id),
        .imm3          (imm3),
        .imm5          (imm5),
        .imm8          (imm8),
        .imm11         (imm11),
        .rd            (rd),
        .rs            (rs),
        .rn            (rn)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [31:0] a);
        if (a == 32'h0)
            return 16'hB5F7;
        return a[16:1] ^ a[31:16] ^ 16'h6D2B;
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Instruction memory: one request at a time, response after lat_cfg cycles (0 = random 1..4)
    logic        mem_vld = 1'b0;
    logic [15:0] mem_dat = 16'h0;
    logic        inj_vld = 1'b0;
    logic [15:0] inj_dat = 16'h0;
    int          lat_cfg = 1;
    bit          busy = 1'b0;
    int          cnt = 0;
    logic [31:0] req_addr = 32'h0;

    assign imem_valid = mem_vld | inj_vld;
    assign imem_rdata = inj_vld ? inj_dat : mem_dat;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_vld = 1'b0;
            busy    = 1'b0;
        end else begin
            mem_vld = 1'b0;
            if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    mem_vld = 1'b1;
                    mem_dat = mem_word(req_addr);
                    busy    = 1'b0;
                end
            end else if (imem_req) begin
                busy     = 1'b1;
                req_addr = imem_addr;
                if (lat_cfg == 0)
                    cnt = int'($urandom_range(1, 4));
                else
                    cnt = lat_cfg;
            end
        end
    end

    // Stream model: decode consumes IF/ID when valid, not stalled and not flushed;
    // consumed entries must be consecutive halfwords from the last redirect point.
    logic [31:0] exp_pc = RESET_PC;
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            exp_pc = RESET_PC;
        end else begin
            if (id_valid && !stall && !branch_taken) begin
                chk32("stream_pc", pc_id, exp_pc);
                chk32("stream_instr", 32'(instr), 32'(mem_word(exp_pc)));
                exp_pc = exp_pc + 32'd2;
                n_cons++;
            end
            if (branch_taken)
                exp_pc = branch_target & ~32'd1;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0;
        lat_cfg = 1;
        repeat (3) @(negedge clk);

        chk32("rst_req", 32'(imem_req), 32'd0);
        chk32("rst_id_valid", 32'(id_valid), 32'd0);
        chk32("rst_instr", 32'(instr), 32'd0);
        chk32("rst_pc_id", pc_id, 32'd0);
        chk32("rst_addr", imem_addr, RESET_PC);
        chk32("rst_imm11", 32'(imm11), 32'd0);

        // Release reset with a stale strobe from a request abandoned by reset
        rst_n = 1'b1;
        inj_vld = 1'b1;
        inj_dat = 16'hDEAD;
        @(negedge clk);
        inj_vld = 1'b0;
        chk32("stale_ignored", 32'(id_valid), 32'd0);
        chk32("first_req", 32'(imem_req), 32'd1);
        chk32("first_addr", imem_addr, RESET_PC);

        // First fetch, latency 1
        for (int i = 0; i < 10; i++) begin
            if (id_valid) break;
            @(negedge clk);
        end
        chk32("f0_valid", 32'(id_valid), 32'd1);
        chk32("f0_instr", 32'(instr), 32'hB5F7);
        chk32("f0_pc", pc_id, 32'h0);
        chk32("f0_imm8", 32'(imm8), 32'hF7);
        chk32("f0_imm3", 32'(imm3), 32'h7);
        chk32("f0_imm11", 32'(imm11), 32'h5F7);
        chk32("f0_imm5", 32'(imm5), 32'h17);
        chk32("f0_rd", 32'(rd), 32'h7);
        chk32("f0_rs", 32'(rs), 32'h6);
        chk32("f0_rn", 32'(rn), 32'h7);
        chk32("f0_next_addr", imem_addr, 32'h2);

        // Stall while instruction 2 sits in IF/ID: response for 4 goes to the skid
        for (int i = 0; i < 10; i++) begin
            if (id_valid && pc_id == 32'h2) break;
            @(negedge clk);
        end
        chk32("s_pc2", pc_id, 32'h2);
        stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!imem_req) break;
            @(negedge clk);
        end
        chk32("skid_req", 32'(imem_req), 32'd0);
        chk32("skid_hold_pc", pc_id, 32'h2);
        chk32("skid_hold_valid", 32'(id_valid), 32'd1);
        repeat (4) begin
            @(negedge clk);
            chk32("skid_wait_req", 32'(imem_req), 32'd0);
            chk32("skid_wait_pc", pc_id, 32'h2);
        end
        stall = 1'b0;
        @(negedge clk);
        chk32("skid_drain_pc", pc_id, 32'h4);
        chk32("skid_drain_valid", 32'(id_valid), 32'd1);
        chk32("skid_drain_req", 32'(imem_req), 32'd1);
        chk32("skid_drain_addr", imem_addr, 32'h6);
        for (int i = 0; i < 10; i++) begin
            if (id_valid && pc_id == 32'h6) break;
            @(negedge clk);
        end
        chk32("s_pc6", pc_id, 32'h6);
        chk32("s_instr6", 32'(instr), 32'(mem_word(32'h6)));

        // Branch while a latency-3 request at 8 is outstanding
        do_reset();
        lat_cfg = 3;
        for (int i = 0; i < 40; i++) begin
            if (imem_req && imem_addr == 32'h8) break;
            @(negedge clk);
        end
        chk32("b_reach8", imem_addr, 32'h8);
        @(negedge clk);
        branch_taken = 1'b1;
        branch_target = 32'h100;
        @(negedge clk);
        branch_taken = 1'b0;
        chk32("disc_req", 32'(imem_req), 32'd1);
        chk32("disc_addr", imem_addr, 32'h8);
        chk32("disc_valid", 32'(id_valid), 32'd0);
        for (int i = 0; i < 10; i++) begin
            if (imem_addr == 32'h100) break;
            chk32("disc_flush", 32'(id_valid), 32'd0);
            @(negedge clk);
        end
        chk32("b_addr100", imem_addr, 32'h100);
        for (int i = 0; i < 20; i++) begin
            if (id_valid) break;
            @(negedge clk);
        end
        chk32("b_pc100", pc_id, 32'h100);
        chk32("b_instr100", 32'(instr), 32'(mem_word(32'h100)));

        // Second redirect while discarding replaces the saved target
        do_reset();
        lat_cfg = 4;
        for (int i = 0; i < 40; i++) begin
            if (imem_req && imem_addr == 32'h4) break;
            @(negedge clk);
        end
        @(negedge clk);
        branch_taken = 1'b1;
        branch_target = 32'h200;
        @(negedge clk);
        branch_target = 32'h300;
        chk32("dd_addr", imem_addr, 32'h4);
        @(negedge clk);
        branch_taken = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (id_valid) break;
            @(negedge clk);
        end
        chk32("dd_pc300", pc_id, 32'h300);

        // Branch and stall together with a live instruction and a full skid
        do_reset();
        lat_cfg = 1;
        for (int i = 0; i < 20; i++) begin
            if (id_valid) break;
            @(negedge clk);
        end
        stall = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!imem_req) break;
            @(negedge clk);
        end
        chk32("bs_live", 32'(id_valid), 32'd1);
        branch_taken = 1'b1;
        branch_target = 32'h41;
        @(negedge clk);
        branch_taken = 1'b0;
        chk32("bs_flush", 32'(id_valid), 32'd0);
        chk32("bs_addr", imem_addr, 32'h40);
        chk32("bs_req", 32'(imem_req), 32'd1);
        stall = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (id_valid) break;
            @(negedge clk);
        end
        chk32("bs_pc40", pc_id, 32'h40);

        // Fetch address wraps past the top of memory
        do_reset();
        lat_cfg = 1;
        @(negedge clk);
        branch_taken = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        @(negedge clk);
        branch_taken = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (id_valid && pc_id == 32'hFFFF_FFFE) break;
            @(negedge clk);
        end
        chk32("wrap_pc", pc_id, 32'hFFFF_FFFE);
        chk32("wrap_addr", imem_addr, 32'h0);

        // Asynchronous reset while parked in the skid state
        stall = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!imem_req) break;
            @(negedge clk);
        end
        chk32("ar_in_skid", 32'(imem_req), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk32("ar_req", 32'(imem_req), 32'd0);
        chk32("ar_valid", 32'(id_valid), 32'd0);
        chk32("ar_instr", 32'(instr), 32'd0);
        chk32("ar_pc", pc_id, 32'd0);
        chk32("ar_addr", imem_addr, RESET_PC);
        chk32("ar_imm8", 32'(imm8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (id_valid) break;
            @(negedge clk);
        end
        chk32("ar_restart_pc", pc_id, RESET_PC);
        chk32("ar_restart_instr", 32'(instr), 32'(mem_word(RESET_PC)));

        // Random stall, redirect and latency traffic
        lat_cfg = 0;
        cons0 = n_cons;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            stall = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 3) == 0)
                branch_target = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else
                branch_target = 32'($urandom_range(0, 255));
        end
        @(negedge clk);
        stall = 1'b0;
        branch_taken = 1'b0;
        repeat (20) @(negedge clk);
        chk32("rand_progress", 32'((n_cons - cons0) > 200), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
